// File: rtl/uart_rx_parity_bit_pkg.sv
// Shared UART definitions: FSM state encodings, parity modes and default link rates.
// The parity transmitter uses the same state encodings.
package uart_pkg;

  localparam int unsigned BASE_CLK_DEF = 50_000_000;
  localparam int unsigned BAUDRATE_DEF = 115_200;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_t;

  // Code 3 is treated as "no parity", the same as code 0.
  function automatic parity_t decode_parity(input logic [1:0] code);
    case (code)
      2'd1:    return PAR_ODD;
      2'd2:    return PAR_EVEN;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_parity_bit_if.sv
// Byte-side bundle of the UART receiver: serial line and parity mode in, byte and status out.
interface uart_rx_parity_bit_if;
  logic       rx_serial;
  logic [1:0] parity_type;
  logic [7:0] out_data;
  logic       data_valid;
  logic       parity_error;
  logic       framing_error;

  modport master (
    output rx_serial, parity_type,
    input  out_data, data_valid, parity_error, framing_error
  );

  modport slave (
    input  rx_serial, parity_type,
    output out_data, data_valid, parity_error, framing_error
  );
endinterface

// File: rtl/uart_rx_parity_bit_sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs; RESET_VAL sets the idle level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_parity_bit.sv
// 8N1 / 8O1 / 8E1 UART receiver: mid-bit sampling, one-cycle valid strobe,
// parity and framing error flags held until the next completed frame.
module uart_rx_parity_bit
  import uart_pkg::*;
#(
  parameter int unsigned BASE_CLK = BASE_CLK_DEF,
  parameter int unsigned BAUDRATE = BAUDRATE_DEF
) (
  input logic                 clk,
  input logic                 rst,
  uart_rx_parity_bit_if.slave bus
);

  localparam int unsigned CLOCKS_PER_BIT = BASE_CLK / BAUDRATE;
  localparam int unsigned HALF_BIT       = CLOCKS_PER_BIT / 2;
  localparam logic [15:0] BIT_LAST       = 16'(CLOCKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST      = 16'(HALF_BIT - 1);

  logic        rx_s;
  uart_state_t state;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  parity_t     par_lat;
  logic        par_err;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rx_serial),
    .q   (rx_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      cnt               <= '0;
      bit_idx           <= '0;
      shift             <= '0;
      par_lat           <= PAR_NONE;
      par_err           <= 1'b0;
      bus.out_data      <= '0;
      bus.data_valid    <= 1'b0;
      bus.parity_error  <= 1'b0;
      bus.framing_error <= 1'b0;
    end else begin
      bus.data_valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          par_err <= 1'b0;
          par_lat <= decode_parity(bus.parity_type);
          if (!rx_s) state <= START;
        end

        START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            // A high line at mid-start is a glitch: drop back without touching outputs.
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shift <= {rx_s, shift[7:1]};
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              state   <= (par_lat != PAR_NONE) ? PARITY : STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            par_err <= (par_lat == PAR_ODD) ? (rx_s != ~^shift) : (rx_s != ^shift);
            state   <= STOP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        STOP: begin
          // Return to IDLE at mid-stop so a start bit right after the stop bit is caught.
          if (cnt == BIT_LAST) begin
            cnt               <= '0;
            bus.out_data      <= shift;
            bus.parity_error  <= par_err;
            bus.framing_error <= ~rx_s;
            bus.data_valid    <= 1'b1;
            state             <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_parity_bit.sv
// Directed bench for uart_rx_parity_bit: table of frames plus glitch, back-to-back and reset sequences.
module tb_uart_rx_parity_bit;

  localparam int unsigned CPB  = 50_000_000 / 115_200;
  localparam int unsigned HALF = CPB / 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #10 clk = ~clk;

  uart_rx_parity_bit_if bus ();

  uart_rx_parity_bit #(
    .BASE_CLK (50_000_000),
    .BAUDRATE (115_200)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned cyc = 0;
  int unsigned start_cyc = 0;

  typedef struct {
    logic [7:0]  d;
    logic        pe;
    logic        fe;
    int unsigned c;
  } ev_t;
  ev_t         evq[$];
  logic        dv_prev = 1'b0;
  int unsigned dv_wide = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.data_valid) begin
      evq.push_back('{d: bus.out_data, pe: bus.parity_error, fe: bus.framing_error, c: cyc});
      if (dv_prev) dv_wide <= dv_wide + 1;
    end
    dv_prev <= bus.data_valid;
  end

  initial begin
    #(150_000 * 20);
    $display("FAIL watchdog: time limit reached, required completion before %0d cycles", 150_000);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic check_range(input string name, input int unsigned act, input int unsigned lo,
                             input int unsigned hi);
    n_total++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic hold(input logic v, input int unsigned n);
    bus.rx_serial = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] pt, input logic [1:0] pt_mid,
                            input logic par_bit, input logic stop_bit, input int unsigned lead);
    bus.parity_type = pt;
    hold(1'b1, lead);
    start_cyc = cyc;
    hold(1'b0, CPB);
    bus.parity_type = pt_mid;
    for (int i = 0; i < 8; i++) hold(d[i], CPB);
    if (pt == 2'd1 || pt == 2'd2) hold(par_bit, CPB);
    if (stop_bit) begin
      hold(1'b1, CPB);
    end else begin
      hold(1'b0, 300);
      hold(1'b1, CPB - 300);
    end
  endtask

  task automatic check_event(input string name, input int idx, input logic [7:0] d,
                             input logic pe, input logic fe);
    if (evq.size() > idx) begin
      check({name, " data"}, {24'h0, evq[idx].d}, {24'h0, d});
      check({name, " parity_error"}, {31'h0, evq[idx].pe}, {31'h0, pe});
      check({name, " framing_error"}, {31'h0, evq[idx].fe}, {31'h0, fe});
    end else begin
      check({name, " pulse present"}, 32'(evq.size()), 32'(idx + 1));
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic [1:0] pt;
    logic [1:0] pt_mid;
    logic       par_bit;
    logic       stop_bit;
    logic [7:0] exp_data;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;
  vec_t vecs[9];

  initial begin
    vecs[0] = '{8'h55, 2'd0, 2'd0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
    vecs[1] = '{8'hA3, 2'd1, 2'd1, 1'b1, 1'b1, 8'hA3, 1'b0, 1'b0};
    vecs[2] = '{8'hA3, 2'd2, 2'd2, 1'b1, 1'b1, 8'hA3, 1'b1, 1'b0};
    vecs[3] = '{8'h0F, 2'd0, 2'd0, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b1};
    vecs[4] = '{8'h01, 2'd0, 2'd0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[5] = '{8'h3C, 2'd3, 2'd3, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[6] = '{8'h96, 2'd2, 2'd2, 1'b0, 1'b1, 8'h96, 1'b0, 1'b0};
    vecs[7] = '{8'h96, 2'd1, 2'd1, 1'b0, 1'b1, 8'h96, 1'b1, 1'b0};
    vecs[8] = '{8'h7F, 2'd1, 2'd0, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0};

    bus.rx_serial   = 1'b1;
    bus.parity_type = 2'd0;
    repeat (5) @(negedge clk);
    check("reset out_data", {24'h0, bus.out_data}, 32'h0);
    check("reset data_valid", {31'h0, bus.data_valid}, 32'h0);
    check("reset parity_error", {31'h0, bus.parity_error}, 32'h0);
    check("reset framing_error", {31'h0, bus.framing_error}, 32'h0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 9; v++) begin
      int unsigned nbits;
      evq.delete();
      send_frame(vecs[v].data, vecs[v].pt, vecs[v].pt_mid, vecs[v].par_bit, vecs[v].stop_bit, 20);
      repeat (10) @(negedge clk);
      check($sformatf("vec%0d pulse count", v), 32'(evq.size()), 32'd1);
      check_event($sformatf("vec%0d", v), 0, vecs[v].exp_data, vecs[v].exp_pe, vecs[v].exp_fe);
      nbits = (vecs[v].pt == 2'd1 || vecs[v].pt == 2'd2) ? 11 : 10;
      if (evq.size() > 0)
        check_range($sformatf("vec%0d latency", v), evq[0].c - start_cyc,
                    nbits * CPB - HALF - 3, nbits * CPB - HALF + 3);
    end

    // Start glitch: 100 clk low must not produce a frame.
    evq.delete();
    bus.parity_type = 2'd0;
    hold(1'b0, 100);
    hold(1'b1, 600);
    check("glitch no pulse", 32'(evq.size()), 32'd0);
    send_frame(8'hC3, 2'd0, 2'd0, 1'b0, 1'b1, 20);
    repeat (10) @(negedge clk);
    check("after glitch pulse count", 32'(evq.size()), 32'd1);
    check_event("after glitch", 0, 8'hC3, 1'b0, 1'b0);

    // Back-to-back even-parity frames, no idle between stop and next start.
    evq.delete();
    send_frame(8'h00, 2'd2, 2'd2, 1'b0, 1'b1, 20);
    send_frame(8'hFF, 2'd2, 2'd2, 1'b0, 1'b1, 0);
    send_frame(8'h81, 2'd2, 2'd2, 1'b0, 1'b1, 0);
    repeat (10) @(negedge clk);
    check("b2b pulse count", 32'(evq.size()), 32'd3);
    check_event("b2b0", 0, 8'h00, 1'b0, 1'b0);
    check_event("b2b1", 1, 8'hFF, 1'b0, 1'b0);
    check_event("b2b2", 2, 8'h81, 1'b0, 1'b0);

    // Reset after data bit 4 of 0x5A.
    evq.delete();
    bus.parity_type = 2'd0;
    hold(1'b1, 20);
    hold(1'b0, CPB);
    for (int i = 0; i < 5; i++) begin
      logic [7:0] b;
      b = 8'h5A;
      hold(b[i], CPB);
    end
    rst = 1'b0;
    #1;
    check("midreset out_data", {24'h0, bus.out_data}, 32'h0);
    check("midreset data_valid", {31'h0, bus.data_valid}, 32'h0);
    check("midreset parity_error", {31'h0, bus.parity_error}, 32'h0);
    check("midreset framing_error", {31'h0, bus.framing_error}, 32'h0);
    hold(1'b1, 5);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("midreset no pulse", 32'(evq.size()), 32'd0);
    send_frame(8'h5A, 2'd0, 2'd0, 1'b0, 1'b1, 20);
    repeat (10) @(negedge clk);
    check("after reset pulse count", 32'(evq.size()), 32'd1);
    check_event("after reset", 0, 8'h5A, 1'b0, 1'b0);

    check("data_valid width", dv_wide, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
